// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, opcodes, aluop codes and control word for the multicycle MIPS control
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWR  = 4'd5,
    MEMWB  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12,
    ERR    = 4'd13
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pc_en;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;
endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: state to control word decode; ADDIEX/ADDIWB decoded only when MC_ADDI_EN is defined
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  input  logic   err_mem,
  output ctrl_t  ctrl
);
  // Moore decode; only FETCH strobes and BRANCH pc_en look at live inputs
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.irwrite = mem_ready;
        ctrl.pc_en   = mem_ready;
      end
      DECODE: ctrl.alusrcb = 2'b11;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.pc_en   = zero;
      end
      JUMP: begin
        ctrl.pcsrc = 2'b10;
        ctrl.pc_en = 1'b1;
      end
`ifdef MC_ADDI_EN
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      ADDIWB: ctrl.regwrite = 1'b1;
`endif
      ERR: begin
        ctrl.illegal_op = ~err_mem;
        ctrl.mem_err    = err_mem;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: multicycle MIPS main FSM with bounded memory waits; MC_ADDI_EN adds addi support
module multicycle_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pc_en,
  output logic       illegal_op,
  output logic       mem_err
);
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_mem_q, err_mem_d;
  logic mem_state, tmo;
  ctrl_t ctrl;
  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign tmo = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (cnt_q == CW'(MEM_TIMEOUT));
  // next state; a timeout diverts any memory wait into ERR
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : state_q;
      DECODE: begin
        if (op == OP_RTYPE) state_d = EXEC;
        else if (op == OP_LW || op == OP_SW) state_d = MEMADR;
        else if (op == OP_BEQ) state_d = BRANCH;
        else if (op == OP_J) state_d = JUMP;
`ifdef MC_ADDI_EN
        else if (op == OP_ADDI) state_d = ADDIEX;
`endif
        else state_d = ERR;
      end
      MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : state_q;
      MEMWR:  state_d = mem_ready ? FETCH : state_q;
      EXEC:   state_d = ALUWB;
`ifdef MC_ADDI_EN
      ADDIEX: state_d = ADDIWB;
`endif
      default: state_d = FETCH;
    endcase
    if (tmo) state_d = ERR;
  end
  // wait counter restarts on every state change and saturates while waiting
  always_comb begin
    cnt_d = (state_d != state_q) ? '0
          : (mem_state && !mem_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    err_mem_d = tmo;
  end
  // state, wait counter and ERR cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_mem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_mem_q <= err_mem_d;
    end
  end
  mc_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .err_mem   (err_mem_q),
    .ctrl      (ctrl)
  );
  assign {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
          alusrcb, aluop, pcsrc, pc_en, illegal_op, mem_err} = ctrl;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: table-driven per-cycle check of the control word plus async reset sequence
module tb_multicycle_main_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic pc_en, illegal_op, mem_err;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    logic        mr;
    logic [16:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [16:0] got;
  logic [16:0] e_zero, e_fetch1, e_fetch0, e_decode, e_memadr, e_memrd, e_memwr, e_memwb;
  logic [16:0] e_exec, e_aluwb, e_br1, e_br0, e_jump, e_ill, e_merr, e_addiex, e_addiwb;

  multicycle_main_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pc_en(pc_en),
    .illegal_op(illegal_op), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  assign got = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, aluop, pcsrc, pc_en, illegal_op, mem_err};

  function automatic logic [16:0] cw(input logic mr, io, mw, ir, rd, mt, rw, sa,
                                     input logic [1:0] sb, ao, ps, input logic pe, il, me);
    return {mr, io, mw, ir, rd, mt, rw, sa, sb, ao, ps, pe, il, me};
  endfunction

  task automatic add(input string n, input logic [5:0] o, input logic z, input logic r,
                     input logic [16:0] e);
    vec_t v;
    v.name = n; v.op = o; v.zero = z; v.mr = r; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [16:0] a, input logic [16:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", n, a, e);
    end
  endtask

  initial begin
    e_zero   = '0;
    e_fetch1 = cw(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0);
    e_fetch0 = cw(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    e_decode = cw(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
    e_memadr = cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    e_memrd  = cw(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    e_memwr  = cw(1,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    e_memwb  = cw(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,0);
    e_exec   = cw(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
    e_aluwb  = cw(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0);
    e_br1    = cw(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,0);
    e_br0    = cw(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,0);
    e_jump   = cw(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);
    e_ill    = cw(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0);
    e_merr   = cw(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,1);
    e_addiex = cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    e_addiwb = cw(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,0);

    add("rt_idle", 6'h00, 0, 1, e_zero);
    add("rt_fetch", 6'h00, 0, 1, e_fetch1);
    add("rt_decode", 6'h00, 0, 1, e_decode);
    add("rt_exec", 6'h00, 0, 1, e_exec);
    add("rt_aluwb", 6'h00, 0, 1, e_aluwb);
    add("lw_fetch", 6'h23, 0, 1, e_fetch1);
    add("lw_decode", 6'h23, 0, 1, e_decode);
    add("lw_memadr", 6'h23, 0, 1, e_memadr);
    for (int i = 0; i < 3; i++) add("lw_memrd_wait", 6'h23, 0, 0, e_memrd);
    add("lw_memrd_done", 6'h23, 0, 1, e_memrd);
    add("lw_memwb", 6'h23, 0, 1, e_memwb);
    add("beq1_fetch", 6'h04, 1, 1, e_fetch1);
    add("beq1_decode", 6'h04, 1, 1, e_decode);
    add("beq1_branch", 6'h04, 1, 1, e_br1);
    add("beq0_fetch", 6'h04, 0, 1, e_fetch1);
    add("beq0_decode", 6'h04, 0, 1, e_decode);
    add("beq0_branch", 6'h04, 0, 1, e_br0);
    add("j_fetch_wait", 6'h02, 0, 0, e_fetch0);
    add("j_fetch", 6'h02, 0, 1, e_fetch1);
    add("j_decode", 6'h02, 0, 1, e_decode);
    add("j_jump", 6'h02, 0, 1, e_jump);
    add("ill_fetch", 6'h3f, 0, 1, e_fetch1);
    add("ill_decode", 6'h3f, 0, 1, e_decode);
    add("ill_err", 6'h3f, 0, 1, e_ill);
    add("ill_refetch", 6'h3f, 0, 1, e_fetch1);
    add("addi_decode", 6'h08, 0, 1, e_decode);
`ifdef MC_ADDI_EN
    add("addi_ex", 6'h08, 0, 1, e_addiex);
    add("addi_wb", 6'h08, 0, 1, e_addiwb);
`else
    add("addi_err", 6'h08, 0, 1, e_ill);
`endif
    add("swt_fetch", 6'h2b, 0, 1, e_fetch1);
    add("swt_decode", 6'h2b, 0, 1, e_decode);
    add("swt_memadr", 6'h2b, 0, 1, e_memadr);
    for (int i = 0; i < 5; i++) add("swt_memwr_stuck", 6'h2b, 0, 0, e_memwr);
    add("swt_err", 6'h2b, 0, 0, e_merr);
    add("swt_refetch", 6'h2b, 0, 1, e_fetch1);
    add("sw_decode", 6'h2b, 0, 1, e_decode);
    add("sw_memadr", 6'h2b, 0, 1, e_memadr);
    for (int i = 0; i < 4; i++) add("sw_memwr_wait", 6'h2b, 0, 0, e_memwr);
    add("sw_memwr_limit_ready", 6'h2b, 0, 1, e_memwr);
    add("sw_next_fetch", 6'h2b, 0, 0, e_fetch0);
    for (int i = 0; i < 4; i++) add("ft_fetch_stuck", 6'h00, 0, 0, e_fetch0);
    add("ft_err", 6'h00, 0, 0, e_merr);
    add("ft_refetch", 6'h00, 0, 0, e_fetch0);

    mem_ready = 1'b1; op = 6'h23; zero = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", got, e_zero);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].mr;
      #1;
      chk(vecs[i].name, got, vecs[i].exp);
      @(negedge clk);
    end

    mem_ready = 1'b1; op = 6'h2b; zero = 1'b0;
    #1 chk("ar_fetch", got, e_fetch1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("ar_memwr", got, e_memwr);
    #2 rst_n = 1'b0;
    #1 chk("ar_async_drop", got, e_zero);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ar_idle", got, e_zero);
    @(negedge clk);
    #1 chk("ar_fetch_after", got, e_fetch0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
